// File: rtl/stack_seq.sv
// stack_seq: op sequencer in front of one Forth stack (push/pop/replace/dup/swap/over).
// Depth tracking and overflow/underflow rejection enabled by defining STACK_SEQ_GUARD_EN.
module stack_seq #(
    parameter int saddr_width = 8,
    parameter int width       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wait_state,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             req_op,
    input  logic [width-1:0]       req_data,
    output logic                   rsp_valid,
    output logic [width-1:0]       rsp_data,
    output logic                   rsp_err,
    output logic                   err_sticky,
    output logic [saddr_width:0]   depth,
    output logic                   stk_wait,
    output logic [width-1:0]       stk_D,
    output logic                   stk_dec,
    output logic                   stk_change,
    output logic                   stk_update,
    input  logic [width-1:0]       stk_Q
);

    typedef enum logic [1:0] {
        IDLE,
        S1,
        S2
    } state_t;

    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_REP  = 3'd3;
    localparam logic [2:0] OP_DUP  = 3'd4;
    localparam logic [2:0] OP_SWAP = 3'd5;
    localparam logic [2:0] OP_OVER = 3'd6;

    state_t           state_q, state_n;
    logic             swap_q, swap_n;
    logic [width-1:0] tmp_q, tmp_n;
    logic [width-1:0] tmp2_q, tmp2_n;
    logic [width-1:0] rsp_data_q, rsp_data_n;
    logic             rsp_valid_q, rsp_valid_n;
    logic             accept;
    logic             rej;

    assign stk_wait  = wait_state;
    assign req_ready = (state_q == IDLE) && !wait_state;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

`ifdef STACK_SEQ_GUARD_EN
    localparam logic [saddr_width:0] CAP = {1'b1, {saddr_width{1'b0}}};
    localparam logic [saddr_width:0] ONE = (saddr_width+1)'(1);
    localparam logic [saddr_width:0] TWO = (saddr_width+1)'(2);

    logic [saddr_width:0] depth_q, depth_n;
    logic                 rsp_err_q, sticky_q;
    logic                 full, empty, lt2;

    assign full       = depth_q == CAP;
    assign empty      = depth_q == '0;
    assign lt2        = depth_q < TWO;
    assign depth      = depth_q;
    assign rsp_err    = rsp_err_q;
    assign err_sticky = sticky_q;

    always_comb begin
        rej = 1'b0;
        case (req_op)
            OP_PUSH:        rej = full;
            OP_POP, OP_REP: rej = empty;
            OP_DUP:         rej = empty | full;
            OP_SWAP:        rej = lt2;
            OP_OVER:        rej = lt2 | full;
            default:        rej = 1'b0;
        endcase
    end

    // Depth moves only on the last execution cycle of an op.
    always_comb begin
        depth_n = depth_q;
        if (accept && !rej) begin
            if (req_op == OP_PUSH || req_op == OP_DUP)
                depth_n = depth_q + ONE;
            else if (req_op == OP_POP)
                depth_n = depth_q - ONE;
        end else if (state_q == S2 && !swap_q) begin
            depth_n = depth_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q   <= '0;
            rsp_err_q <= 1'b0;
            sticky_q  <= 1'b0;
        end else if (!wait_state) begin
            depth_q   <= depth_n;
            rsp_err_q <= accept && rej;
            if (accept && rej)
                sticky_q <= 1'b1;
        end
    end
`else
    assign rej        = 1'b0;
    assign depth      = '0;
    assign rsp_err    = 1'b0;
    assign err_sticky = 1'b0;
`endif

    always_comb begin
        state_n     = state_q;
        swap_n      = swap_q;
        tmp_n       = tmp_q;
        tmp2_n      = tmp2_q;
        rsp_valid_n = 1'b0;
        rsp_data_n  = rsp_data_q;
        stk_D       = '0;
        stk_dec     = 1'b0;
        stk_change  = 1'b0;
        stk_update  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    rsp_valid_n = 1'b1;
                    if (rej) begin
                        rsp_data_n = '0;
                    end else begin
                        case (req_op)
                            OP_PUSH: begin
                                stk_change = 1'b1;
                                stk_update = 1'b1;
                                stk_D      = req_data;
                                rsp_data_n = req_data;
                            end
                            OP_POP: begin
                                stk_change = 1'b1;
                                stk_dec    = 1'b1;
                                rsp_data_n = stk_Q;
                            end
                            OP_REP: begin
                                stk_update = 1'b1;
                                stk_D      = req_data;
                                rsp_data_n = req_data;
                            end
                            OP_DUP: begin
                                stk_change = 1'b1;
                                stk_update = 1'b1;
                                stk_D      = stk_Q;
                                rsp_data_n = stk_Q;
                            end
                            OP_SWAP, OP_OVER: begin
                                // Pop T into tmp so N becomes readable.
                                stk_change  = 1'b1;
                                stk_dec     = 1'b1;
                                tmp_n       = stk_Q;
                                swap_n      = req_op == OP_SWAP;
                                state_n     = S1;
                                rsp_valid_n = 1'b0;
                            end
                            default: rsp_data_n = stk_Q;
                        endcase
                    end
                end
            end
            S1: begin
                tmp2_n     = stk_Q;
                stk_update = 1'b1;
                stk_D      = tmp_q;
                stk_change = !swap_q;
                state_n    = S2;
            end
            S2: begin
                stk_change  = 1'b1;
                stk_update  = 1'b1;
                stk_D       = tmp2_q;
                rsp_valid_n = 1'b1;
                rsp_data_n  = tmp2_q;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            swap_q      <= 1'b0;
            tmp_q       <= '0;
            tmp2_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else if (!wait_state) begin
            state_q     <= state_n;
            swap_q      <= swap_n;
            tmp_q       <= tmp_n;
            tmp2_q      <= tmp2_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_data_q  <= rsp_data_n;
        end
    end

endmodule

// File: doc/stack_seq.md
Name: stack_seq

Overview:
- Sequencer in front of one `stack` instance (data or return stack) in the Forth core.
- Accepts one stack operation at a time over a valid/ready handshake and drives the stack's dec/change/update/D controls over 1 or 3 cycles.
- Tracks stack depth, rejects operations that would overflow or underflow, and returns a result word per operation.
- Multi-cycle ops (SWAP, OVER) exist because the stack exposes only the top-of-stack read port.

Parameters:
- saddr_width, 8, stack address width; capacity CAP = 2**saddr_width entries
- width, 16, data word width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- wait_state  in  1  global stall; freezes sequencer and stack
- req_valid  in  1  operation request
- req_ready  out  1  sequencer can accept a request this cycle
- req_op  in  3  0 NOP, 1 PUSH, 2 POP, 3 REPLACE, 4 DUP, 5 SWAP, 6 OVER, 7 reserved (treated as NOP)
- req_data  in  width  operand for PUSH and REPLACE
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  width  result word, see Behaviour
- rsp_err  out  1  operation rejected (qualified by rsp_valid)
- err_sticky  out  1  set on any rejection; cleared only by reset
- depth  out  saddr_width+1  current entry count, 0..CAP
- stk_wait  out  1  to stack.wait_state
- stk_D  out  width  to stack.D
- stk_dec  out  1  to stack.dec
- stk_change  out  1  to stack.change
- stk_update  out  1  to stack.update
- stk_Q  in  width  from stack.Q (combinational mem[SP])

Behaviour:
- Reset: state IDLE, depth=0, rsp_valid=0, rsp_err=0, err_sticky=0, rsp_data=0, tmp=0. Reset also resets the stack SP; the two stay aligned.
- stk_wait = wait_state. While wait_state=1, all registers hold, req_ready=0, and the stk_* controls are don't-care because the stack is frozen.
- req_ready = (state==IDLE) && !wait_state. An op is accepted when req_valid && req_ready. The accept cycle is execution cycle 1: stk_* are driven combinationally from req_op in IDLE.
- T denotes stk_Q in the accept cycle; N denotes the entry below T.
- PUSH (1 cycle): change=1, dec=0, update=1, D=req_data. depth+1. rsp_data=req_data.
- POP (1 cycle): change=1, dec=1, update=0. depth-1. rsp_data=T.
- REPLACE (1 cycle): change=0, update=1, D=req_data. depth unchanged. rsp_data=req_data.
- DUP (1 cycle): change=1, dec=0, update=1, D=T. depth+1. rsp_data=T.
- SWAP (3 cycles):
  - Accept cycle: pop, tmp<=T.
  - S1: change=0, update=1, D=tmp, tmp2<=stk_Q (N).
  - S2: push D=tmp2.
  - Net depth 0. rsp_data=N. Final order ... T N.
- OVER (3 cycles):
  - Accept cycle: pop, tmp<=T.
  - S1: tmp2<=stk_Q (N); push D=tmp.
  - S2: push D=tmp2.
  - Net depth +1. rsp_data=N. Final order ... N T N.
- NOP and reserved opcodes: all stk_* controls 0; rsp_valid pulses with rsp_data=stk_Q and rsp_err=0.
- Idle default when no request is accepted: change=0, update=0, dec=0, D=0.
- Response timing: rsp_valid rises in the first non-wait cycle after the final execution cycle and lasts one non-wait cycle.
  - Back-to-back 1-cycle ops sustain 1 op/cycle.
  - SWAP and OVER hold req_ready=0 during S1 and S2.
- Guard checks (see Optional Feature) are evaluated at accept, using depth before the op:
  - Underflow: POP, REPLACE or DUP with depth==0; SWAP or OVER with depth<2.
  - Overflow: PUSH, DUP or OVER with depth==CAP.
  - A rejected op issues no stack activity (all stk_* controls 0), completes in 1 cycle, sets rsp_err=1 and err_sticky=1, and rsp_data=0.
- depth update lands with the final cycle of the op; depth is never observed in a transient state.
- A reset asserted mid SWAP/OVER aborts the op: state returns to IDLE with no response, and stack SP returns to 0.

Optional Feature:
- Macro STACK_SEQ_GUARD_EN.
- Defined: depth counter maintained and overflow/underflow rejection as above.
- Undefined: no checks. All ops execute and SP wraps modulo CAP. depth, rsp_err and err_sticky are tied to 0.

Test Plan:
- Reset, PUSH 0x1111, PUSH 0x2222, POP -> rsp_data 0x2222, depth 1, stk_Q 0x1111.
- PUSH 0xA, PUSH 0xB, SWAP -> req_ready low 2 cycles, rsp_data 0xA; POP,POP return 0xA then 0xB.
- PUSH 0x5, PUSH 0x6, OVER -> depth 3; POPs return 0x5, 0x6, 0x5.
- Guard on, depth 0, POP -> rsp_err=1, err_sticky=1, depth 0, stk_change=0. CAP pushes then PUSH -> rsp_err=1, depth=CAP.
- wait_state=1 for 3 cycles in SWAP S1 -> state, tmp and rsp held; completes with correct result after release.
- Reset asserted in OVER S1 -> IDLE, depth 0, no rsp_valid. Next PUSH 0x7 then POP -> rsp_data 0x7.
